fp_cvt_rr_arbiter: RTL and testbench

- Shares one pipelined float-to-u32 converter (34-bit FloPoCo single-precision in, 32-bit unsigned out, NUM_STAGES pipeline registers gated by ce) among NUM_REQ requesters.
- Round-robin arbitration at the converter input, at most one issue per cycle.
- A tag pipeline runs in lockstep with the converter and routes each result back to its originating requester.
- Sits between the per-lane issue logic and the shared conversion datapath.

---
 rtl/fp_cvt_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fp_cvt_rr_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cvt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fp_cvt_rr_arbiter
//
// Shares one pipelined float-to-u32 converter (34-bit FloPoCo single-precision
// operand in, 32-bit unsigned result out) among NUM_REQ requesters. A
// round-robin arbiter picks at most one operand per clock-enabled cycle and
// drives it onto the converter input. A {vld, id} tag pipeline of depth LATENCY
// advances in lockstep with the converter and steers each result back to the
// requester that issued it.
//
// Parameters
//   NUM_REQ  number of requesters (2..16)
//   LATENCY  converter pipeline depth; must equal the converter's NUM_STAGES.
//            0 means the converter is combinational.
//   ID_W     width of a requester index
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   ce         clock enable, shared with the converter
//   req_valid  per-requester request valid                 [NUM_REQ]
//   req_data   per-requester operand, requester i at [34*i+33:34*i]
//   req_ready  per-requester accept strobe (at most one hot) [NUM_REQ]
//   cvt_I      operand to the converter input               [34]
//   cvt_O      result from the converter output             [32]
//   rsp_valid  one-hot result strobe                        [NUM_REQ]
//   rsp_data   converted unsigned result                    [32]
//   rsp_id     requester index of the current result        [ID_W]
//   stat_grant_cnt  (only with FP_CVT_ARB_STATS_EN) one saturating 16-bit
//                   grant counter per requester, requester i at [16*i+15:16*i]
//
// Optional feature macro: FP_CVT_ARB_STATS_EN
//
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i].
// The requester holds req_valid and req_data stable until that transfer.
// req_ready is combinational from req_valid, ptr and ce. The response side has
// no backpressure: each rsp_valid pulse must be consumed on the cycle it shows.
// -----------------------------------------------------------------------------
module fp_cvt_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*34-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [33:0]           cvt_I,
   input  logic [31:0]           cvt_O,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_data,
   output logic [ID_W-1:0]       rsp_id
`ifdef FP_CVT_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] stat_grant_cnt
`endif
);

   logic [ID_W-1:0] ptr;
   logic            grant_any;
   logic [ID_W-1:0] grant_id;
   logic            tail_vld;
   logic [ID_W-1:0] tail_id;
   logic            rsp_fire;

   // Scan ptr, ptr+1, ... (mod NUM_REQ); the first valid requester wins.
   // With ce low nothing is granted, so req_ready stays all-zero.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (ce && !grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      cvt_I     = 34'h0;
      if (grant_any) begin
         req_ready = NUM_REQ'(1) << grant_id;
         cvt_I     = req_data[34*grant_id +: 34];
      end
   end

   // Pointer moves to one past the winner; it holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_any) begin
         if (grant_id == ID_W'(NUM_REQ-1))
            ptr <= '0;
         else
            ptr <= grant_id + 1'b1;
      end
   end

   // Tag pipeline mirroring the converter stages.
   generate
      if (LATENCY == 0) begin : g_tag_comb
         assign tail_vld = grant_any;
         assign tail_id  = grant_id;
      end else begin : g_tag_pipe
         logic [LATENCY-1:0] vld_q;
         logic [ID_W-1:0]    id_q [LATENCY];

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
            end else if (ce) begin
               vld_q[0] <= grant_any;
               for (int s = 1; s < LATENCY; s++)
                  vld_q[s] <= vld_q[s-1];
            end
         end

         // Ids are only meaningful alongside a set vld bit, so they need no reset.
         always_ff @(posedge clk) begin
            if (ce) begin
               id_q[0] <= grant_id;
               for (int s = 1; s < LATENCY; s++)
                  id_q[s] <= id_q[s-1];
            end
         end

         assign tail_vld = vld_q[LATENCY-1];
         assign tail_id  = id_q[LATENCY-1];
      end
   endgenerate

   // A result is emitted only on a ce cycle, the cycle it leaves the pipeline.
   assign rsp_fire = ce && tail_vld;

   always_comb begin
      rsp_valid = '0;
      rsp_id    = '0;
      rsp_data  = '0;
      if (rsp_fire) begin
         rsp_valid = NUM_REQ'(1) << tail_id;
         rsp_id    = tail_id;
         rsp_data  = cvt_O;
      end
   end

`ifdef FP_CVT_ARB_STATS_EN
   logic [15:0] grant_cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++)
            grant_cnt_q[i] <= '0;
      end else if (grant_any && grant_cnt_q[grant_id] != 16'hFFFF) begin
         grant_cnt_q[grant_id] <= grant_cnt_q[grant_id] + 16'd1;
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_out
      assign stat_grant_cnt[16*gi +: 16] = grant_cnt_q[gi];
   end
`endif

endmodule

// File: tb/tb_fp_cvt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_cvt_rr_arbiter
//
// Directed, table-driven bench for fp_cvt_rr_arbiter with NUM_REQ=4 and
// LATENCY=2. A small behavioural float-to-u32 converter with two ce-gated
// stages stands in for the shared datapath. Each table row drives rst/ce/
// req_valid for one cycle and lists the hand-computed req_ready, cvt_I and
// response outputs for that cycle. Hand-written sequences cover reset during
// flight and (with FP_CVT_ARB_STATS_EN) the grant counters.
// -----------------------------------------------------------------------------
module tb_fp_cvt_rr_arbiter;
   localparam int NUM_REQ = 4;
   localparam int LATENCY = 2;
   localparam int ID_W    = 2;

   // Operands: 1.0f, 100.0f, 2.0f, 3.0f in FloPoCo format (exception bits 01).
   localparam logic [33:0] D0 = 34'h1_3F80_0000;
   localparam logic [33:0] D1 = 34'h1_42C8_0000;
   localparam logic [33:0] D2 = 34'h1_4000_0000;
   localparam logic [33:0] D3 = 34'h1_4040_0000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst;
   logic                  ce;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*34-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic [33:0]           cvt_I;
   logic [31:0]           cvt_O;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_data;
   logic [ID_W-1:0]       rsp_id;
`ifdef FP_CVT_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] stat_grant_cnt;
`endif

   fp_cvt_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .LATENCY (LATENCY),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cvt_I     (cvt_I),
      .cvt_O     (cvt_O),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef FP_CVT_ARB_STATS_EN
      ,
      .stat_grant_cnt (stat_grant_cnt)
`endif
   );

   // ---------------- converter model ----------------
   function automatic logic [31:0] fp2u(input logic [33:0] x);
      logic [23:0] mant;
      int          sh;
      if (x[33:32] != 2'b01 || x[31]) return 32'h0;
      if (x[30:23] < 8'd127) return 32'h0;
      sh = int'(x[30:23]) - 127;
      if (sh > 31) return 32'hFFFF_FFFF;
      mant = {1'b1, x[22:0]};
      if (sh >= 23) return 32'(mant) << (sh - 23);
      return 32'(mant >> (23 - sh));
   endfunction

   logic [31:0] cv_s0 = '0;
   logic [31:0] cv_s1 = '0;
   always @(posedge clk) begin
      if (ce) begin
         cv_s0 <= fp2u(cvt_I);
         cv_s1 <= cv_s0;
      end
   end
   assign cvt_O = cv_s1;

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change at the falling edge; outputs are sampled 1 ns later,
   // well before the next rising edge.
   task automatic drive(input logic r, input logic c, input logic [NUM_REQ-1:0] v);
      @(negedge clk);
      rst       = r;
      ce        = c;
      req_valid = v;
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic [3:0] rv,
                          input logic [1:0] id, input logic [31:0] d);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(rv));
      chk({tag, "_rsp_id"},    64'(rsp_id),    64'(id));
      chk({tag, "_rsp_data"},  64'(rsp_data),  64'(d));
   endtask

   typedef struct {
      logic        rst;
      logic        ce;
      logic [3:0]  valid;
      logic [3:0]  exp_ready;
      logic [33:0] exp_i;
      logic [3:0]  exp_rv;
      logic [1:0]  exp_id;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic c, input logic [3:0] v,
                      input logic [3:0] rdy, input logic [33:0] i,
                      input logic [3:0] rv, input logic [1:0] id, input logic [31:0] d);
      vec_t t;
      t.rst = r; t.ce = c; t.valid = v; t.exp_ready = rdy; t.exp_i = i;
      t.exp_rv = rv; t.exp_id = id; t.exp_data = d;
      vecs.push_back(t);
   endtask

   initial begin
      rst       = 1'b1;
      ce        = 1'b1;
      req_valid = '0;
      req_data  = {D3, D2, D1, D0};

      //   rst ce  valid    ready    cvt_I  rsp_v    id  data
      // single requester 1 (ptr 0 -> 2)
      add(0, 1, 4'b0010, 4'b0010, D1,   4'b0000, 0, 0);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0000, 0, 0);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0010, 1, 100);
      // reset returns ptr to 0
      add(1, 1, 4'b0000, 4'b0000, 34'h0, 4'b0000, 0, 0);
      // all four valid: 0,1,2,3,0,1 with responses two cycles behind
      add(0, 1, 4'b1111, 4'b0001, D0,   4'b0000, 0, 0);
      add(0, 1, 4'b1111, 4'b0010, D1,   4'b0000, 0, 0);
      add(0, 1, 4'b1111, 4'b0100, D2,   4'b0001, 0, 1);
      add(0, 1, 4'b1111, 4'b1000, D3,   4'b0010, 1, 100);
      add(0, 1, 4'b1111, 4'b0001, D0,   4'b0100, 2, 2);
      add(0, 1, 4'b1111, 4'b0010, D1,   4'b1000, 3, 3);
      // ptr=2: grant 2 -> ptr=3; then {2,3} valid -> 3 first, then 2
      add(0, 1, 4'b0100, 4'b0100, D2,   4'b0001, 0, 1);
      add(0, 1, 4'b1100, 4'b1000, D3,   4'b0010, 1, 100);
      add(0, 1, 4'b0100, 4'b0100, D2,   4'b0100, 2, 2);
      // requester 0 alone -> ptr=1
      add(0, 1, 4'b0001, 4'b0001, D0,   4'b1000, 3, 3);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0100, 2, 2);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0001, 0, 1);
      // ptr=1 with {0,3}: scan 1,2,3 -> grant 3, then wrap to 0
      add(0, 1, 4'b1001, 4'b1000, D3,   4'b0000, 0, 0);
      add(0, 1, 4'b0001, 4'b0001, D0,   4'b0000, 0, 0);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b1000, 3, 3);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0001, 0, 1);
      // two in flight, then ce low for 3 cycles
      add(0, 1, 4'b0001, 4'b0001, D0,   4'b0000, 0, 0);
      add(0, 1, 4'b0010, 4'b0010, D1,   4'b0000, 0, 0);
      add(0, 0, 4'b0100, 4'b0000, 34'h0, 4'b0000, 0, 0);
      add(0, 0, 4'b0100, 4'b0000, 34'h0, 4'b0000, 0, 0);
      add(0, 0, 4'b0100, 4'b0000, 34'h0, 4'b0000, 0, 0);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0001, 0, 1);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0010, 1, 100);
      add(0, 1, 4'b0000, 4'b0000, 34'h0, 4'b0000, 0, 0);

      repeat (2) @(posedge clk);

      // reset state
      drive(0, 1, 4'b0000);
      chk("reset_req_ready", 64'(req_ready), 64'h0);
      chk_rsp("reset", 4'b0000, 2'd0, 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].ce, vecs[i].valid);
         chk($sformatf("r%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
         chk($sformatf("r%0d_cvt_I", i),     64'(cvt_I),     64'(vecs[i].exp_i));
         chk_rsp($sformatf("r%0d", i), vecs[i].exp_rv, vecs[i].exp_id, vecs[i].exp_data);
      end

      // Reset one cycle after a grant of FloPoCo zero (ptr is 2 here).
      req_data[2*34 +: 34] = 34'h0;
      drive(0, 1, 4'b0100);
      chk("rstflight_ready", 64'(req_ready), 64'b0100);
      chk("rstflight_cvt_I", 64'(cvt_I), 64'h0);
      drive(1, 1, 4'b0000);
      chk("rstflight_rst_rsp_valid", 64'(rsp_valid), 64'h0);
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 4'b0000);
         chk($sformatf("rstflight_drop%0d_rsp_valid", i), 64'(rsp_valid), 64'h0);
      end
      req_data[2*34 +: 34] = D2;
      // ptr back at 0: {1,3} valid -> grant 1
      drive(0, 1, 4'b1010);
      chk("rstflight_next_ready", 64'(req_ready), 64'b0010);
      chk("rstflight_next_cvt_I", 64'(cvt_I), 64'(D1));
      drive(0, 1, 4'b0000);
      chk("rstflight_gap_rsp_valid", 64'(rsp_valid), 64'h0);
      drive(0, 1, 4'b0000);
      chk_rsp("rstflight_next", 4'b0010, 2'd1, 32'd100);

`ifdef FP_CVT_ARB_STATS_EN
      drive(1, 1, 4'b0000);
      drive(0, 1, 4'b0000);
      chk("stat_after_reset", 64'(stat_grant_cnt), 64'h0);
      repeat (5) drive(0, 1, 4'b0001);
      drive(0, 0, 4'b0001);   // ce low: no grant, counters hold
      repeat (2) drive(0, 1, 4'b1000);
      drive(0, 1, 4'b0000);
      chk("stat_cnt0", 64'(stat_grant_cnt[15:0]),  64'd5);
      chk("stat_cnt1", 64'(stat_grant_cnt[31:16]), 64'd0);
      chk("stat_cnt2", 64'(stat_grant_cnt[47:32]), 64'd0);
      chk("stat_cnt3", 64'(stat_grant_cnt[63:48]), 64'd2);
`endif

      drive(0, 1, 4'b0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
